// File: rtl/router_pkg.sv
// Shared router constants: port count, flit layout, port-index width and starvation threshold.
package router_pkg;

    localparam int REN       = 5;
    localparam int PL        = 8;
    localparam int PORT_W    = 3;
    localparam int MAX_WAIT  = 7;
    localparam int FLIT_FLAG = 0;

    // Round-robin successor of an index within n ports.
    function automatic logic [PORT_W-1:0] wrap_inc(input logic [PORT_W-1:0] p, input int n);
        if (int'(p) >= n - 1)
            return '0;
        return p + 1'b1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational winner picker for one output: starving candidates first, else round-robin from ptr.
module rr_pick
    import router_pkg::*;
#(
    parameter int REN    = router_pkg::REN,
    parameter int PORT_W = router_pkg::PORT_W
) (
    input  logic [REN-1:0]    cand,
    input  logic [REN-1:0]    starve,
    input  logic [PORT_W-1:0] ptr,
    output logic              found,
    output logic [PORT_W-1:0] idx
);

    always_comb begin
        logic hit;
        int   j;
        hit   = 1'b0;
        j     = 0;
        idx   = '0;
        for (int i = 0; i < REN; i++) begin
            if (!hit && cand[i] && starve[i]) begin
                hit = 1'b1;
                idx = PORT_W'(i);
            end
        end
        for (int k = 0; k < REN; k++) begin
            j = (int'(ptr) + k) % REN;
            if (!hit && cand[j]) begin
                hit = 1'b1;
                idx = PORT_W'(j);
            end
        end
        found = |cand;
    end

endmodule

// File: rtl/output_scheduler.sv
// Per-output arbitration of input queue heads with round-robin fairness and starvation priority.
module output_scheduler
    import router_pkg::*;
#(
    parameter int REN      = router_pkg::REN,
    parameter int PL       = router_pkg::PL,
    parameter int MAX_WAIT = router_pkg::MAX_WAIT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid [0:REN-1],
    input  logic [PORT_W-1:0] req_port  [0:REN-1],
    input  logic [0:PL-1]     req_data  [0:REN-1],
    input  logic              avail_in  [0:REN-1],
    output logic              grant     [0:REN-1],
    output logic [0:PL-1]     out_data  [0:REN-1],
    output logic              drop
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    logic [PORT_W-1:0] ptr       [REN];
    logic [WAIT_W-1:0] wait_cnt  [REN];
    logic [REN-1:0]    cand_mask [REN];
    logic [REN-1:0]    starve_mask;
    logic [REN-1:0]    pick_found;
    logic [PORT_W-1:0] pick_idx  [REN];
    logic [REN-1:0]    win;
    logic [REN-1:0]    illegal;
    logic [REN-1:0]    grant_raw;
    logic [0:PL-1]     sel_data  [REN];

    always_comb begin
        starve_mask = '0;
        illegal     = '0;
        for (int o = 0; o < REN; o++)
            cand_mask[o] = '0;
        for (int i = 0; i < REN; i++) begin
            starve_mask[i] = (wait_cnt[i] == WAIT_W'(MAX_WAIT));
            illegal[i]     = req_valid[i] && (int'(req_port[i]) >= REN);
            for (int o = 0; o < REN; o++)
                cand_mask[o][i] = req_valid[i] && (req_port[i] == PORT_W'(o));
        end
    end

    for (genvar o = 0; o < REN; o++) begin : g_pick
        rr_pick #(
            .REN    (REN),
            .PORT_W (PORT_W)
        ) u_rr_pick (
            .cand   (cand_mask[o]),
            .starve (starve_mask),
            .ptr    (ptr[o]),
            .found  (pick_found[o]),
            .idx    (pick_idx[o])
        );
    end

    always_comb begin
        win       = '0;
        grant_raw = illegal;
        for (int o = 0; o < REN; o++) begin
            win[o]      = avail_in[o] && pick_found[o];
            sel_data[o] = '0;
            for (int i = 0; i < REN; i++) begin
                if (pick_idx[o] == PORT_W'(i)) begin
                    sel_data[o] = req_data[i];
                    if (win[o])
                        grant_raw[i] = 1'b1;
                end
            end
        end
        for (int i = 0; i < REN; i++)
            grant[i] = grant_raw[i] && !rst;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drop <= 1'b0;
            for (int o = 0; o < REN; o++) begin
                out_data[o] <= '0;
                ptr[o]      <= '0;
                wait_cnt[o] <= '0;
            end
        end else begin
            drop <= |illegal;
            for (int o = 0; o < REN; o++) begin
                if (win[o]) begin
                    out_data[o] <= sel_data[o];
                    ptr[o]      <= wrap_inc(pick_idx[o], REN);
                end else begin
                    out_data[o] <= '0;
                end
            end
            // A head that is absent, discarded or granted restarts its wait; only denied heads age.
            for (int i = 0; i < REN; i++) begin
                if (!req_valid[i] || grant_raw[i])
                    wait_cnt[i] <= '0;
                else if (wait_cnt[i] != WAIT_W'(MAX_WAIT))
                    wait_cnt[i] <= wait_cnt[i] + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_output_scheduler.sv
// Directed self-checking bench for output_scheduler with hand-computed expectations.
module tb_output_scheduler;

    localparam int REN = 5;
    localparam int PL  = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            req_valid [0:REN-1];
    logic [2:0]      req_port  [0:REN-1];
    logic [0:PL-1]   req_data  [0:REN-1];
    logic            avail_in  [0:REN-1];
    logic            grant     [0:REN-1];
    logic [0:PL-1]   out_data  [0:REN-1];
    logic            drop;

    int errors = 0;
    int checks = 0;

    output_scheduler dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_port  (req_port),
        .req_data  (req_data),
        .avail_in  (avail_in),
        .grant     (grant),
        .out_data  (out_data),
        .drop      (drop)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] grant_vec();
        logic [4:0] v;
        for (int i = 0; i < REN; i++) v[i] = grant[i];
        return v;
    endfunction

    function automatic logic [39:0] out_vec();
        logic [39:0] v;
        for (int o = 0; o < REN; o++) v[o*8 +: 8] = out_data[o];
        return v;
    endfunction

    task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        for (int i = 0; i < REN; i++) begin
            req_valid[i] = 1'b0;
            req_port[i]  = 3'd0;
            req_data[i]  = 8'h00;
            avail_in[i]  = 1'b1;
        end
    endtask

    task automatic set_req(input int i, input logic [2:0] p, input logic [7:0] d);
        req_valid[i] = 1'b1;
        req_port[i]  = p;
        req_data[i]  = d;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        set_req(0, 3'd0, 8'h55);
        #1;
        chk("grant_in_reset", 40'(grant_vec()), 40'h0);
        tick();
        tick();
        chk("reset_out", out_vec(), 40'h0);
        chk("reset_drop", 40'(drop), 40'h0);
        rst = 1'b0;
        idle();

        // single request
        set_req(2, 3'd0, 8'h90);
        #1;
        chk("single_grant", 40'(grant_vec()), 40'h04);
        tick();
        idle();
        chk("single_out", out_vec(), 40'h90);
        tick();
        chk("single_clear", out_vec(), 40'h0);

        // contention for output 4
        do_reset();
        set_req(0, 3'd4, 8'hA0);
        set_req(1, 3'd4, 8'hB0);
        set_req(3, 3'd4, 8'hC0);
        #1;
        chk("rr_grant0", 40'(grant_vec()), 40'h01);
        tick();
        chk("rr_out0", 40'(out_data[4]), 40'hA0);
        chk("rr_grant1", 40'(grant_vec()), 40'h02);
        tick();
        chk("rr_out1", 40'(out_data[4]), 40'hB0);
        chk("rr_grant3", 40'(grant_vec()), 40'h08);
        tick();
        chk("rr_out3", 40'(out_data[4]), 40'hC0);
        chk("rr_grant0b", 40'(grant_vec()), 40'h01);
        tick();
        chk("rr_out0b", out_vec(), {8'hA0, 32'h0});

        // backpressure and starvation
        do_reset();
        avail_in[1] = 1'b0;
        set_req(4, 3'd1, 8'h44);
        for (int c = 0; c < 9; c++) begin
            #1;
            chk($sformatf("bp_nogrant_%0d", c), 40'(grant_vec()), 40'h0);
            tick();
        end
        chk("bp_out_idle", out_vec(), 40'h0);
        avail_in[1] = 1'b1;
        set_req(0, 3'd1, 8'h11);
        #1;
        chk("starve_win", 40'(grant_vec()), 40'h10);
        tick();
        chk("starve_out", 40'(out_data[1]), 40'h44);
        req_valid[4] = 1'b0;
        #1;
        chk("after_starve_grant", 40'(grant_vec()), 40'h01);
        tick();
        chk("after_starve_out", 40'(out_data[1]), 40'h11);

        // illegal port
        idle();
        set_req(3, 3'd6, 8'hEE);
        #1;
        chk("illegal_grant", 40'(grant_vec()), 40'h08);
        tick();
        idle();
        chk("illegal_drop", 40'(drop), 40'h1);
        chk("illegal_out", out_vec(), 40'h0);
        tick();
        chk("drop_pulse_end", 40'(drop), 40'h0);

        // parallel permutation
        for (int i = 0; i < REN; i++) set_req(i, 3'(4 - i), 8'(8'h80 + i));
        #1;
        chk("par_grant", 40'(grant_vec()), 40'h1F);
        tick();
        idle();
        chk("par_out", out_vec(), 40'h80_81_82_83_84);

        // reset in the cycle input 1 would be granted
        do_reset();
        set_req(0, 3'd2, 8'h01);
        set_req(1, 3'd2, 8'h02);
        #1;
        chk("mid_grant0", 40'(grant_vec()), 40'h01);
        tick();
        chk("mid_out0", 40'(out_data[2]), 40'h01);
        rst = 1'b1;
        #1;
        chk("mid_grant_gated", 40'(grant_vec()), 40'h0);
        tick();
        chk("mid_reset_out", out_vec(), 40'h0);
        rst = 1'b0;
        #1;
        chk("mid_ptr_zero", 40'(grant_vec()), 40'h01);
        tick();
        chk("mid_post_out", 40'(out_data[2]), 40'h01);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/output_scheduler.md
OUTPUT_SCHEDULER -- requirements
Module: output_scheduler

Interface
REQ-001 Parameter REN, default 5, number of router ports (local + 4 mesh directions), index 0..REN-1.
REQ-002 Parameter PL, default 8, flit width; bit 0 (MSB-first [0:PL-1] ordering) is the valid flag.
REQ-003 Parameter MAX_WAIT, default 7, cycles an input may be denied before it gains starvation priority.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 req_valid[0:REN-1]  input  1 each  head flit of input queue i is present.
REQ-007 req_port[0:REN-1]  input  3 each  output index selected by XY routing for queue i head.
REQ-008 req_data[0:REN-1]  input  PL each  head flit of queue i.
REQ-009 avail_in[0:REN-1]  input  1 each  downstream of output o accepts a flit this cycle.
REQ-010 grant[0:REN-1]  output  1 each  combinational dequeue (shift) pulse to queue i.
REQ-011 out_data[0:REN-1]  output  PL each  registered flit driven on output o.
REQ-012 drop  output  1  registered pulse: at least one head with illegal req_port was discarded.

Function
REQ-013 Candidates for output o: inputs i with req_valid[i]=1 and req_port[i]=o.
REQ-014 If avail_in[o]=0, no candidate for o is granted and all their wait counters increment.
REQ-015 If avail_in[o]=1 and candidates exist, exactly one is granted in the same cycle (grant[i]=1, combinational).
REQ-016 Winner selection: starving candidates (wait_cnt=MAX_WAIT) first, lowest index among them; otherwise first candidate searching cyclically from ptr[o] upward, wrapping REN-1 -> 0.
REQ-017 On a grant to i for output o: ptr[o] <= (i+1) mod REN; wait_cnt[i] <= 0; out_data[o] <= req_data[i] at the next edge.
REQ-018 Output latency exactly 1 cycle from grant; a flit appears on out_data[o] for exactly one cycle.
REQ-019 Output o with no grant in a cycle: out_data[o] <= 0 at the next edge; ptr[o] unchanged.
REQ-020 Denied valid candidate: wait_cnt[i] <= min(wait_cnt[i]+1, MAX_WAIT) (saturating, never wraps).
REQ-021 req_port[i] >= REN with req_valid[i]=1: grant[i]=1 same cycle (head discarded), no output driven, drop <= 1 next edge; wait_cnt[i] <= 0.
REQ-022 req_valid[i]=0: grant[i]=0, wait_cnt[i] <= 0.
REQ-023 Each input receives at most one grant per cycle; distinct outputs are granted independently in the same cycle.
REQ-024 grant never asserts while rst=1.

Reset
REQ-025 While rst=1 at an edge: every out_data[o] <= 0, drop <= 0, every ptr[o] <= 0, every wait_cnt[i] <= 0.
REQ-026 Reset mid-operation discards any flit granted in that cycle; first post-reset arbitration uses ptr=0.

Structure
REQ-027 REN, PL, port-index width (3), MAX_WAIT and the flit-flag bit position live in shared package router_pkg.
REQ-028 One sub-module rr_pick (per-output round-robin plus starvation picker, purely combinational) instantiated REN times; pointers, counters and output registers stay in output_scheduler.

Verification
REQ-029 Single request: input 2 req_port=0, data 8'h90, avail_in=all 1 -> grant[2] same cycle, out_data[0]=8'h90 next cycle, 8'h00 the cycle after.
REQ-030 Contention: inputs 0,1,3 all target output 4 every cycle with flits A0/B0/C0 -> grants rotate 0,1,3,0 on consecutive cycles after reset.
REQ-031 Backpressure: avail_in[1]=0 for 9 cycles while input 4 targets port 1 -> no grant, wait_cnt[4] saturates at 7; when input 0 also targets port 1 and ptr[1]=0, input 4 wins on release.
REQ-032 Illegal port: input 3 req_port=6, valid=1 -> grant[3]=1 same cycle, drop=1 next cycle, all out_data=0.
REQ-033 Parallel: inputs 0..4 target outputs 4,3,2,1,0 with data 8'h80..8'h84 -> all five granted in one cycle, each output carries its flit next cycle.
REQ-034 Reset mid-stream: rst=1 in the cycle input 1 is granted -> out_data all 0 next cycle, ptr and counters 0.
